// File: rtl/sdram_pkg.sv
// Shared SDRAM command encodings, idle bus constants and the arbiter state type.
package sdram_pkg;
  // {cs_n, ras_n, cas_n, we_n}
  localparam logic [3:0]  CMD_NOP_P   = 4'b0111;
  localparam logic [3:0]  CMD_PREC_P  = 4'b0010;
  localparam logic [3:0]  CMD_AREF_P  = 4'b0001;
  localparam logic [3:0]  CMD_ACT_P   = 4'b0011;
  localparam logic [3:0]  CMD_WRITE_P = 4'b0100;
  localparam logic [3:0]  CMD_READ_P  = 4'b0101;
  localparam logic [3:0]  CMD_MRS_P   = 4'b0000;
  localparam logic [1:0]  IDLE_BANK_P = 2'b11;
  localparam logic [12:0] IDLE_ADDR_P = 13'h1fff;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARBIT = 3'd1,
    ST_AREF  = 3'd2,
    ST_WRITE = 3'd3,
    ST_READ  = 3'd4
  } arb_state_e;
endpackage

// File: rtl/sdram_arbit_if.sv
// Stage request/command buses into the arbiter and its grant/pin outputs.
interface sdram_arbit_if;
  logic        init_end;
  logic [3:0]  init_cmd;
  logic [1:0]  init_bank;
  logic [12:0] init_addr;
  logic        aref_req, aref_end;
  logic [3:0]  aref_cmd;
  logic [1:0]  aref_bank;
  logic [12:0] aref_addr;
  logic        wr_req, wr_end;
  logic [3:0]  wr_cmd;
  logic [1:0]  wr_bank;
  logic [12:0] wr_addr;
  logic        wr_sdram_en;
  logic [15:0] wr_sdram_data;
  logic        rd_req, rd_end;
  logic [3:0]  rd_cmd;
  logic [1:0]  rd_bank;
  logic [12:0] rd_addr;
  logic        aref_en, wr_en, rd_en;
  logic        sdram_cke;
  logic        sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
  logic [1:0]  sdram_ba;
  logic [12:0] sdram_addr;

  modport master (
    output init_end, init_cmd, init_bank, init_addr,
    output aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    output wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    output rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    input  aref_en, wr_en, rd_en, sdram_cke,
    input  sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );

  modport slave (
    input  init_end, init_cmd, init_bank, init_addr,
    input  aref_req, aref_end, aref_cmd, aref_bank, aref_addr,
    input  wr_req, wr_end, wr_cmd, wr_bank, wr_addr, wr_sdram_en, wr_sdram_data,
    input  rd_req, rd_end, rd_cmd, rd_bank, rd_addr,
    output aref_en, wr_en, rd_en, sdram_cke,
    output sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n, sdram_ba, sdram_addr
  );
endinterface

// File: rtl/sdram_arbit.sv
// Fixed-priority (refresh > write > read) SDRAM stage arbiter with command mux.
module sdram_arbit
  import sdram_pkg::*;
#(
  parameter logic [3:0]  CMD_NOP   = CMD_NOP_P,
  parameter logic [1:0]  IDLE_BANK = IDLE_BANK_P,
  parameter logic [12:0] IDLE_ADDR = IDLE_ADDR_P
) (
  input  logic             clk,
  input  logic             rstn,
  sdram_arbit_if.slave     bus,
  inout  wire  [15:0]      sdram_dq
);

  arb_state_e  r_state;
  arb_state_e  w_next;
  logic [3:0]  w_cmd;
  logic [1:0]  w_bank;
  logic [12:0] w_addr;

  always_ff @(posedge clk) begin
    if (!rstn) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // A grant is only left via its own end pulse, so foreign ends are ignored.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (bus.init_end) w_next = ST_ARBIT;
      ST_ARBIT: begin
        if      (bus.aref_req) w_next = ST_AREF;
        else if (bus.wr_req)   w_next = ST_WRITE;
        else if (bus.rd_req)   w_next = ST_READ;
      end
      ST_AREF:  if (bus.aref_end) w_next = ST_ARBIT;
      ST_WRITE: if (bus.wr_end)   w_next = ST_ARBIT;
      ST_READ:  if (bus.rd_end)   w_next = ST_ARBIT;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cmd  = CMD_NOP;
    w_bank = IDLE_BANK;
    w_addr = IDLE_ADDR;
    case (r_state)
      ST_IDLE:  begin w_cmd = bus.init_cmd; w_bank = bus.init_bank; w_addr = bus.init_addr; end
      ST_AREF:  begin w_cmd = bus.aref_cmd; w_bank = bus.aref_bank; w_addr = bus.aref_addr; end
      ST_WRITE: begin w_cmd = bus.wr_cmd;   w_bank = bus.wr_bank;   w_addr = bus.wr_addr;   end
      ST_READ:  begin w_cmd = bus.rd_cmd;   w_bank = bus.rd_bank;   w_addr = bus.rd_addr;   end
      default:  ;
    endcase
  end

  assign bus.aref_en    = (r_state == ST_AREF);
  assign bus.wr_en      = (r_state == ST_WRITE);
  assign bus.rd_en      = (r_state == ST_READ);
  assign bus.sdram_cke  = 1'b1;
  assign {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n} = w_cmd;
  assign bus.sdram_ba   = w_bank;
  assign bus.sdram_addr = w_addr;

  assign sdram_dq = ((r_state == ST_WRITE) && bus.wr_sdram_en) ? bus.wr_sdram_data : 16'hzzzz;

endmodule

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit; released DQ reads as all-ones through pullups.
module tb_sdram_arbit;
  logic clk = 1'b0;
  logic rstn;
  wire [15:0] dq;
  int n_tests = 0;
  int n_fail  = 0;

  sdram_arbit_if bus();

  sdram_arbit dut (.clk(clk), .rstn(rstn), .bus(bus), .sdram_dq(dq));

  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (dq[g]);
  end

  always #5 clk = ~clk;

  localparam logic [15:0] DQ_Z = 16'hffff;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] pins();
    return {bus.sdram_cs_n, bus.sdram_ras_n, bus.sdram_cas_n, bus.sdram_we_n};
  endfunction

  function automatic logic [2:0] ens();
    return {bus.aref_en, bus.wr_en, bus.rd_en};
  endfunction

  initial begin
    rstn = 1'b0;
    bus.init_end = 1'b0; bus.init_cmd = 4'b0010; bus.init_bank = 2'b01; bus.init_addr = 13'h0123;
    bus.aref_req = 1'b0; bus.aref_end = 1'b0;
    bus.aref_cmd = 4'b0001; bus.aref_bank = 2'b10; bus.aref_addr = 13'h0400;
    bus.wr_req = 1'b0; bus.wr_end = 1'b0;
    bus.wr_cmd = 4'b0100; bus.wr_bank = 2'b01; bus.wr_addr = 13'h0055;
    bus.wr_sdram_en = 1'b1; bus.wr_sdram_data = 16'hA5A5;
    bus.rd_req = 1'b0; bus.rd_end = 1'b0;
    bus.rd_cmd = 4'b0101; bus.rd_bank = 2'b00; bus.rd_addr = 13'h00AA;

    // Reset: IDLE passes init bus through
    tick(); tick();
    chk("rst_cmd",  32'(pins()), 32'h2);
    chk("rst_bank", 32'(bus.sdram_ba), 32'h1);
    chk("rst_addr", 32'(bus.sdram_addr), 32'h0123);
    chk("rst_en",   32'(ens()), 32'h0);
    chk("rst_dq",   32'(dq), 32'(DQ_Z));
    chk("rst_cke",  32'(bus.sdram_cke), 32'h1);

    rstn = 1'b1;
    tick();
    chk("idle_hold_cmd", 32'(pins()), 32'h2);

    bus.init_end = 1'b1;
    tick();
    chk("arbit_cmd",  32'(pins()), 32'h7);
    chk("arbit_bank", 32'(bus.sdram_ba), 32'h3);
    chk("arbit_addr", 32'(bus.sdram_addr), 32'h1fff);
    chk("arbit_en",   32'(ens()), 32'h0);

    // All three requests at once: refresh wins
    bus.aref_req = 1'b1; bus.wr_req = 1'b1; bus.rd_req = 1'b1;
    tick();
    chk("prio_en",   32'(ens()), 32'h4);
    chk("aref_cmd",  32'(pins()), 32'h1);
    chk("aref_bank", 32'(bus.sdram_ba), 32'h2);
    chk("aref_addr", 32'(bus.sdram_addr), 32'h0400);

    // init_end dropping outside IDLE is ignored
    bus.init_end = 1'b0;
    tick();
    chk("init_drop_en", 32'(ens()), 32'h4);

    bus.aref_req = 1'b0; bus.aref_end = 1'b1;
    tick();
    bus.aref_end = 1'b0;
    chk("aref_exit_en",  32'(ens()), 32'h0);
    chk("aref_exit_cmd", 32'(pins()), 32'h7);

    tick();
    chk("wr_en",   32'(ens()), 32'h2);
    chk("wr_cmd",  32'(pins()), 32'h4);
    chk("wr_addr", 32'(bus.sdram_addr), 32'h0055);
    chk("wr_dq",   32'(dq), 32'hA5A5);
    bus.wr_sdram_en = 1'b0;
    #1;
    chk("wr_dq_off", 32'(dq), 32'(DQ_Z));
    bus.wr_sdram_en = 1'b1;

    // Refresh arriving mid-write waits for wr_end
    bus.aref_req = 1'b1;
    tick();
    chk("no_preempt", 32'(ens()), 32'h2);
    bus.wr_end = 1'b1;
    tick();
    bus.wr_end = 1'b0;
    chk("wr_exit_en",  32'(ens()), 32'h0);
    chk("wr_exit_cmd", 32'(pins()), 32'h7);
    tick();
    chk("aref_after_wr", 32'(ens()), 32'h4);
    tick();
    chk("aref_held", 32'(ens()), 32'h4);

    bus.aref_req = 1'b0; bus.aref_end = 1'b1;
    tick();
    bus.aref_end = 1'b0;
    chk("arbit2_en", 32'(ens()), 32'h0);
    // Write drops before being granted: read goes instead
    bus.wr_req = 1'b0;
    tick();
    chk("rd_en",   32'(ens()), 32'h1);
    chk("rd_cmd",  32'(pins()), 32'h5);
    chk("rd_bank", 32'(bus.sdram_ba), 32'h0);
    chk("rd_addr", 32'(bus.sdram_addr), 32'h00AA);
    chk("rd_dq",   32'(dq), 32'(DQ_Z));

    bus.aref_end = 1'b1; bus.wr_end = 1'b1;
    tick();
    bus.aref_end = 1'b0; bus.wr_end = 1'b0;
    chk("stray_end", 32'(ens()), 32'h1);

    bus.rd_req = 1'b0; bus.rd_end = 1'b1;
    tick();
    bus.rd_end = 1'b0;
    chk("rd_exit_en",  32'(ens()), 32'h0);
    chk("rd_exit_cmd", 32'(pins()), 32'h7);
    tick();
    chk("arbit_idle_en", 32'(ens()), 32'h0);

    // Reset in the middle of a refresh grant
    bus.aref_req = 1'b1;
    tick();
    chk("aref3_en", 32'(ens()), 32'h4);
    rstn = 1'b0;
    tick();
    chk("rst_mid_en",   32'(ens()), 32'h0);
    chk("rst_mid_cmd",  32'(pins()), 32'h2);
    chk("rst_mid_bank", 32'(bus.sdram_ba), 32'h1);
    chk("rst_mid_addr", 32'(bus.sdram_addr), 32'h0123);
    rstn = 1'b1;
    tick();
    chk("idle_no_grant", 32'(ens()), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
